// File: rtl/reservation_station_pkg.sv
// Shared types for the reservation station: physical tag width and the
// per-entry payload carried from rename to issue.
package reservation_station_pkg;
  localparam int PREG_W    = 6;
  localparam int NUM_PREGS = 64;
  localparam int OPC_W     = 7;
  localparam int INSTR_W   = 32;

  typedef logic [PREG_W-1:0] preg_t;

  typedef struct packed {
    logic [OPC_W-1:0]   opcode;
    preg_t              ps1;
    logic               rdy1;
    preg_t              ps2;
    logic               rdy2;
    preg_t              pd;
    logic [INSTR_W-1:0] instr;
  } rs_entry_t;

  // Apply one writeback broadcast to an entry's source-ready bits.
  function automatic rs_entry_t wake(rs_entry_t e, logic v, preg_t tag);
    rs_entry_t r;
    r      = e;
    r.rdy1 = e.rdy1 | (v && (e.ps1 == tag));
    r.rdy2 = e.rdy2 | (v && (e.ps2 == tag));
    return r;
  endfunction
endpackage

// File: rtl/reservation_station_if.sv
// Dispatch / wakeup / issue bundle between rename, writeback and execute.
interface reservation_station_if #(parameter int DEPTH = 16);
  import reservation_station_pkg::*;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic               disp_valid;
  logic               disp_ready;
  logic [OPC_W-1:0]   disp_opcode;
  preg_t              disp_ps1;
  preg_t              disp_ps2;
  logic               disp_ps1_rdy;
  logic               disp_ps2_rdy;
  preg_t              disp_pd;
  logic [INSTR_W-1:0] disp_instr;
  logic               wb_valid;
  preg_t              wb_tag;
  logic               issue_valid;
  logic               issue_ready;
  logic [OPC_W-1:0]   issue_opcode;
  preg_t              issue_ps1;
  preg_t              issue_ps2;
  preg_t              issue_pd;
  logic [INSTR_W-1:0] issue_instr;
  logic [CNT_W-1:0]   count;

  modport master (
    output disp_valid, disp_opcode, disp_ps1, disp_ps2, disp_ps1_rdy, disp_ps2_rdy,
           disp_pd, disp_instr, wb_valid, wb_tag, issue_ready,
    input  disp_ready, issue_valid, issue_opcode, issue_ps1, issue_ps2, issue_pd,
           issue_instr, count
  );

  modport slave (
    input  disp_valid, disp_opcode, disp_ps1, disp_ps2, disp_ps1_rdy, disp_ps2_rdy,
           disp_pd, disp_instr, wb_valid, wb_tag, issue_ready,
    output disp_ready, issue_valid, issue_opcode, issue_ps1, issue_ps2, issue_pd,
           issue_instr, count
  );
endinterface

// File: rtl/reservation_station_select.sv
// Lowest-index priority select over the per-slot ready vector.
module rs_select #(
  parameter int N = 16,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  output logic [N-1:0]     gnt_oh,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             any
);
  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        gnt_oh  = N'(1) << i;
        gnt_idx = IDX_W'(i);
      end
    end
    any = |req;
  end
endmodule

// File: rtl/reservation_station.sv
// Age-ordered collapsing-queue reservation station: slot 0 is oldest,
// occupied slots are always 0..count-1, issue removes and shifts down.
module reservation_station
  import reservation_station_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input logic                  clk,
  input logic                  reset,
  reservation_station_if.slave rs
);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int IDX_W = $clog2(DEPTH);

  rs_entry_t [DEPTH-1:0] ent_q, ent_d;
  rs_entry_t [DEPTH:0]   woke;
  logic [CNT_W-1:0]      count_q, count_d, ins;
  logic [DEPTH-1:0]      req, gnt_oh;
  logic [IDX_W-1:0]      sel;
  logic                  any, fire, accept;
  rs_entry_t             new_ent, sel_ent;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      woke[i] = wake(ent_q[i], rs.wb_valid, rs.wb_tag);
      req[i]  = (CNT_W'(i) < count_q) && ent_q[i].rdy1 && ent_q[i].rdy2;
    end
    // Extra zero slot so the top entry has something to shift in from.
    woke[DEPTH] = '0;
  end

  rs_select #(.N(DEPTH)) u_sel (
    .req     (req),
    .gnt_oh  (gnt_oh),
    .gnt_idx (sel),
    .any     (any)
  );

  // One-hot AND-OR mux: naturally all-zero payload when nothing is ready.
  always_comb begin
    sel_ent = '0;
    for (int i = 0; i < DEPTH; i++)
      if (gnt_oh[i]) sel_ent = sel_ent | ent_q[i];
  end

  assign fire   = any && rs.issue_ready;
  assign accept = rs.disp_valid && rs.disp_ready;
  assign ins    = fire ? count_q - CNT_W'(1) : count_q;

  always_comb begin
    new_ent = wake('{opcode: rs.disp_opcode, ps1: rs.disp_ps1, rdy1: rs.disp_ps1_rdy,
                     ps2: rs.disp_ps2, rdy2: rs.disp_ps2_rdy, pd: rs.disp_pd,
                     instr: rs.disp_instr}, rs.wb_valid, rs.wb_tag);
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = (fire && (IDX_W'(i) >= sel)) ? woke[i+1] : woke[i];
      if (accept && (CNT_W'(i) == ins)) ent_d[i] = new_ent;
    end
    unique case ({accept, fire})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      ent_q   <= '0;
    end else begin
      count_q <= count_d;
      ent_q   <= ent_d;
    end
  end

  assign rs.disp_ready   = count_q < CNT_W'(DEPTH);
  assign rs.issue_valid  = any;
  assign rs.issue_opcode = sel_ent.opcode;
  assign rs.issue_ps1    = sel_ent.ps1;
  assign rs.issue_ps2    = sel_ent.ps2;
  assign rs.issue_pd     = sel_ent.pd;
  assign rs.issue_instr  = sel_ent.instr;
  assign rs.count        = count_q;
endmodule
